// File: rtl/timing_track_writer.sv
// timing_track_writer
//   Regenerates the TM timing track and CN number track on the drum during
//   track initialisation. A pass synchronises to the index pulse, writes one
//   full revolution, reads that revolution back, and reports how many cells
//   mismatched. One bit cell is handled per CLOCK.
//
// Ports
//   CLOCK    in   bit-cell clock
//   rst_n    in   asynchronous active-low reset
//   start    in   begin a write/verify pass (level, honoured in IDLE and DONE)
//   abort    in   cancel the pass from any non-idle state
//   index    in   index pulse, high during the cell before word 0, bit 0
//   TM_rd    in   TM track read-back
//   CN_rd    in   CN track read-back
//   TM_wr    out  TM write data
//   CN_wr    out  CN write data
//   WR_EN    out  drum write enable for both tracks
//   busy     out  high in SYNC, WRITE, VERIFY
//   done     out  high in DONE
//   pass     out  verify succeeded (valid while done=1)
//   err_cnt  out  mismatching cells, saturating at 255
//   word     out  word counter, 0..WORDS-1
//   bit_t    out  bit-time counter, 0..BITS-1
module timing_track_writer #(
    parameter int unsigned BITS         = 29,
    parameter int unsigned WORDS        = 108,
    parameter logic [BITS-1:0] TM_V     = 29'b0_1101000_1_1100000_01_10000_00000_0,
    parameter int unsigned SYNC_TIMEOUT = 4096
) (
    input  logic       CLOCK,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       index,
    input  logic       TM_rd,
    input  logic       CN_rd,
    output logic       TM_wr,
    output logic       CN_wr,
    output logic       WR_EN,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic [6:0] word,
    output logic [4:0] bit_t
);

    localparam int unsigned TW = $clog2(SYNC_TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StWrite,
        StVerify,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [6:0]      word_q, word_d;
    logic [4:0]      bit_q, bit_d;
    logic [7:0]      err_q, err_d;
    logic            pass_q, pass_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    logic            exp_tm;
    logic            exp_cn;
    logic            last_bit;
    logic            last_word;
    logic            mismatch;
    logic [7:0]      err_inc;

    assign exp_tm    = TM_V[bit_q];
    assign exp_cn    = (word_q != 7'(WORDS - 1));
    assign last_bit  = (bit_q == 5'(BITS - 1));
    assign last_word = (word_q == 7'(WORDS - 1));
    // A cell where both tracks disagree still counts as a single error.
    assign mismatch  = (TM_rd != exp_tm) || (CN_rd != exp_cn);
    assign err_inc   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            word_q  <= '0;
            bit_q   <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            bit_q   <= bit_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        bit_d   = bit_q;
        err_d   = err_q;
        pass_d  = pass_q;
        tmo_d   = tmo_q;

        if (abort && (state_q != StIdle)) begin
            // err_cnt is deliberately kept so maintenance logic can inspect it.
            state_d = StIdle;
            word_d  = '0;
            bit_d   = '0;
            pass_d  = 1'b0;
            tmo_d   = '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_d = StSync;
                        err_d   = '0;
                        pass_d  = 1'b0;
                        tmo_d   = '0;
                        word_d  = '0;
                        bit_d   = '0;
                    end
                end
                StSync: begin
                    if (index) begin
                        state_d = StWrite;
                        word_d  = '0;
                        bit_d   = '0;
                    end else if (tmo_q == TW'(SYNC_TIMEOUT - 1)) begin
                        state_d = StDone;
                        err_d   = 8'hFF;
                        pass_d  = 1'b0;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                StWrite, StVerify: begin
                    if (state_q == StVerify && mismatch) begin
                        err_d = err_inc;
                    end
                    if (last_bit) begin
                        bit_d  = '0;
                        word_d = last_word ? 7'd0 : word_q + 7'd1;
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                    // WRITE flows straight into VERIFY with no gap cell.
                    if (last_bit && last_word) begin
                        if (state_q == StWrite) begin
                            state_d = StVerify;
                        end else begin
                            state_d = StDone;
                            pass_d  = (err_d == 8'd0);
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign WR_EN   = (state_q == StWrite);
    assign TM_wr   = WR_EN & exp_tm;
    assign CN_wr   = WR_EN & exp_cn;
    assign busy    = (state_q == StSync) || (state_q == StWrite) || (state_q == StVerify);
    assign done    = (state_q == StDone);
    assign pass    = pass_q;
    assign err_cnt = err_q;
    assign word    = word_q;
    assign bit_t   = bit_q;

endmodule

// File: tb/tb_timing_track_writer.sv
// Directed testbench for timing_track_writer: loops the write tracks through
// a drum model and checks pattern, verify result, timeout, abort and reset.
module tb_timing_track_writer;

    localparam int CELLS = 108 * 29;
    localparam logic [28:0] TMV = 29'b0_1101000_1_1100000_01_10000_00000_0;

    logic       CLOCK;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       index;
    logic       TM_rd;
    logic       CN_rd;
    logic       TM_wr;
    logic       CN_wr;
    logic       WR_EN;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_cnt;
    logic [6:0] word;
    logic [4:0] bit_t;

    int checks = 0;
    int errors = 0;
    int mode   = 0;       // 0 clean, 1 injected faults, 2 TM stuck-at-0
    int wr_cnt = 0;
    int wa;
    logic [28:0] tmv = TMV;
    logic drum_tm [0:CELLS-1];
    logic drum_cn [0:CELLS-1];

    timing_track_writer dut (
        .CLOCK   (CLOCK),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .index   (index),
        .TM_rd   (TM_rd),
        .CN_rd   (CN_rd),
        .TM_wr   (TM_wr),
        .CN_wr   (CN_wr),
        .WR_EN   (WR_EN),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .err_cnt (err_cnt),
        .word    (word),
        .bit_t   (bit_t)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Drum model: the cell under the head is addressed by the rotation position.
    assign wa = int'(word) * 29 + int'(bit_t);

    always @(posedge CLOCK) begin
        if (WR_EN) begin
            drum_tm[wa] <= TM_wr;
            drum_cn[wa] <= CN_wr;
            wr_cnt      <= wr_cnt + 1;
        end
    end

    always_comb begin
        TM_rd = 1'b0;
        CN_rd = 1'b0;
        if (wa < CELLS) begin
            TM_rd = drum_tm[wa];
            CN_rd = drum_cn[wa];
        end
        if (mode == 1) begin
            if (word == 7'd5 && bit_t == 5'd3) TM_rd = ~TM_rd;
            if (word == 7'd50 && bit_t == 5'd0) begin
                TM_rd = ~TM_rd;
                CN_rd = ~CN_rd;
            end
        end else if (mode == 2) begin
            TM_rd = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge CLOCK);
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // From SYNC: wait dly cells, pulse index, then run the whole pass while
    // counting cells whose outputs deviate from the expected write/verify view.
    task automatic run_pass(input int dly, output int perr);
        int w;
        int b;
        perr = 0;
        for (int i = 0; i < dly; i++) step();
        index = 1'b1;
        step();
        index = 1'b0;
        for (int n = 0; n < 2 * CELLS; n++) begin
            w = (n % CELLS) / 29;
            b = (n % CELLS) % 29;
            if (word !== 7'(w) || bit_t !== 5'(b) || busy !== 1'b1 || done !== 1'b0) perr++;
            if (n < CELLS) begin
                if (WR_EN !== 1'b1 || TM_wr !== tmv[b] || CN_wr !== (w != 107)) perr++;
            end else begin
                if (WR_EN !== 1'b0 || TM_wr !== 1'b0 || CN_wr !== 1'b0) perr++;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({WR_EN, TM_wr, CN_wr, busy, done, pass} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000000", {WR_EN, TM_wr, CN_wr, busy, done, pass});
        end
        checks++;
        if (err_cnt !== 8'd0 || word !== 7'd0 || bit_t !== 5'd0) begin
            errors++;
            $display("FAIL reset_counters: err %0d word %0d bit %0d want 0 0 0", err_cnt, word, bit_t);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_clean();
        int perr;
        int wr0;
        wr0 = wr_cnt;
        kick();
        checks++;
        if (busy !== 1'b1 || WR_EN !== 1'b0) begin
            errors++;
            $display("FAIL clean_sync: busy %b wr_en %b want 1 0", busy, WR_EN);
        end
        run_pass(9, perr);
        checks++;
        if (perr !== 0) begin
            errors++;
            $display("FAIL clean_pattern: %0d bad cells want 0", perr);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clean_latency: done %b busy %b want 1 0 after 6264 cells", done, busy);
        end
        checks++;
        if (pass !== 1'b1 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clean_result: pass %b err %0d want 1 0", pass, err_cnt);
        end
        checks++;
        if (wr_cnt - wr0 !== CELLS) begin
            errors++;
            $display("FAIL clean_wr_cycles: got %0d want %0d", wr_cnt - wr0, CELLS);
        end
    endtask

    task automatic test_fault();
        int perr;
        mode = 1;
        kick();
        run_pass(4, perr);
        mode = 0;
        checks++;
        if (err_cnt !== 8'd2 || pass !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL fault_count: err %0d pass %b done %b want 2 0 1", err_cnt, pass, done);
        end
    endtask

    task automatic test_restart();
        int perr;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || pass !== 1'b0 || err_cnt !== 8'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_clear: done %b pass %b err %0d busy %b want 0 0 0 1",
                     done, pass, err_cnt, busy);
        end
        run_pass(5, perr);
        checks++;
        if (perr !== 0 || pass !== 1'b1 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL restart_pass: bad %0d pass %b err %0d want 0 1 0", perr, pass, err_cnt);
        end
    endtask

    task automatic test_stuck();
        int perr;
        mode = 2;
        kick();
        run_pass(2, perr);
        mode = 0;
        checks++;
        if (err_cnt !== 8'd255 || pass !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL stuck_saturate: err %0d pass %b done %b want 255 0 1", err_cnt, pass, done);
        end
    endtask

    task automatic test_timeout();
        int perr;
        int wr0;
        perr = 0;
        wr0  = wr_cnt;
        index = 1'b0;
        kick();
        for (int i = 0; i < 4095; i++) begin
            step();
            if (done !== 1'b0 || WR_EN !== 1'b0 || busy !== 1'b1) perr++;
        end
        checks++;
        if (perr !== 0) begin
            errors++;
            $display("FAIL timeout_early: %0d bad cycles want 0", perr);
        end
        step();
        checks++;
        if (done !== 1'b1 || pass !== 1'b0 || err_cnt !== 8'd255) begin
            errors++;
            $display("FAIL timeout_done: done %b pass %b err %0d want 1 0 255", done, pass, err_cnt);
        end
        checks++;
        if (wr_cnt - wr0 !== 0) begin
            errors++;
            $display("FAIL timeout_wr_en: %0d write cycles want 0", wr_cnt - wr0);
        end
    endtask

    task automatic test_abort_write();
        kick();
        index = 1'b1;
        step();
        index = 1'b0;
        for (int i = 0; i < 40 * 29; i++) step();
        checks++;
        if (WR_EN !== 1'b1 || word !== 7'd40 || bit_t !== 5'd0) begin
            errors++;
            $display("FAIL abort_pre: wr_en %b word %0d bit %0d want 1 40 0", WR_EN, word, bit_t);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (WR_EN !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || word !== 7'd0 || bit_t !== 5'd0) begin
            errors++;
            $display("FAIL abort_write: wr_en %b busy %b done %b word %0d bit %0d want 0 0 0 0 0",
                     WR_EN, busy, done, word, bit_t);
        end
    endtask

    task automatic test_abort_verify();
        mode = 1;
        kick();
        index = 1'b1;
        step();
        index = 1'b0;
        // Stop in VERIFY word 10: only the word 5 fault has been seen.
        for (int i = 0; i < CELLS + 10 * 29; i++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        mode  = 0;
        checks++;
        if (err_cnt !== 8'd1 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
            errors++;
            $display("FAIL abort_verify: err %0d busy %b done %b pass %b want 1 0 0 0",
                     err_cnt, busy, done, pass);
        end
    endtask

    task automatic test_reset_mid_write();
        kick();
        index = 1'b1;
        step();
        index = 1'b0;
        for (int i = 0; i < 40 * 29; i++) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (WR_EN !== 1'b0 || busy !== 1'b0 || word !== 7'd0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_async: wr_en %b busy %b word %0d err %0d want 0 0 0 0",
                     WR_EN, busy, word, err_cnt);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_start_abort_idle();
        start = 1'b1;
        abort = 1'b1;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || WR_EN !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_idle: busy %b done %b wr_en %b want 0 0 0", busy, done, WR_EN);
        end
        start = 1'b0;
        abort = 1'b0;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        index = 1'b0;
        test_reset();
        test_clean();
        test_fault();
        test_restart();
        test_stuck();
        test_timeout();
        test_abort_write();
        test_abort_verify();
        test_reset_mid_write();
        test_start_abort_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
